// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mult/div sequencer: FSM state encoding,
// operation type and default rstatus codes reported on unit exceptions.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    localparam int DEF_RSTATUS_MUL = 4;
    localparam int DEF_RSTATUS_DIV = 5;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decode, muldiv-unit and writeback signals of the sequencer, bundled in one
// interface; slave is the sequencer's view, master the surrounding pipeline's.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             op_valid;
    logic             op_is_mul;
    logic             op_is_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [TAG_W-1:0] op_tag;
    logic             flush;
    logic             stall;
    logic             unit_ctrl_mult;
    logic             unit_ctrl_div;
    logic [WIDTH-1:0] unit_a;
    logic [WIDTH-1:0] unit_b;
    logic [WIDTH-1:0] unit_result;
    logic             unit_exception;
    logic             unit_ready;
    logic             wb_valid;
    logic [WIDTH-1:0] wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_exception;
    logic [WIDTH-1:0] wb_rstatus;
    logic             wb_ack;

    modport slave (
        input  op_valid, op_is_mul, op_is_div, op_a, op_b, op_tag, flush,
        input  unit_result, unit_exception, unit_ready, wb_ack,
        output stall, unit_ctrl_mult, unit_ctrl_div, unit_a, unit_b,
        output wb_valid, wb_data, wb_tag, wb_exception, wb_rstatus
    );

    modport master (
        output op_valid, op_is_mul, op_is_div, op_a, op_b, op_tag, flush,
        output unit_result, unit_exception, unit_ready, wb_ack,
        input  stall, unit_ctrl_mult, unit_ctrl_div, unit_a, unit_b,
        input  wb_valid, wb_data, wb_tag, wb_exception, wb_rstatus
    );

endinterface

// File: rtl/muldiv_timeout_counter.sv
// Up-counter bounding how long the sequencer waits for the muldiv unit;
// expired flags the enabled cycle that brings the count up to LIMIT.
module muldiv_timeout_counter #(
    parameter int CNT_W = 6,
    parameter int LIMIT = 40
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multi-cycle mult/div unit: accepts one op, issues a
// single start pulse, waits for ready or timeout, and holds the result for writeback.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TAG_W       = 5,
    parameter int TIMEOUT     = 40,
    parameter int CNT_W       = 6,
    parameter int RSTATUS_MUL = DEF_RSTATUS_MUL,
    parameter int RSTATUS_DIV = DEF_RSTATUS_DIV
) (
    input logic               clock,
    input logic               reset_n,
    muldiv_sequencer_if.slave bus
);

    state_t           state, state_next;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q, wb_data_q, wb_rstatus_q, fault_rstatus;
    logic [TAG_W-1:0] tag_q, wb_tag_q;
    logic             wb_exception_q;
    logic             accept, timeout, wb_load, wb_clear;
    logic             stall, ctrl_mult, ctrl_div, wb_valid;

    assign accept        = bus.op_valid & (bus.op_is_mul | bus.op_is_div) & ~bus.flush;
    assign fault_rstatus = (op_q == OP_MUL) ? WIDTH'(RSTATUS_MUL) : WIDTH'(RSTATUS_DIV);

    muldiv_timeout_counter #(.CNT_W(CNT_W), .LIMIT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state == START),
        .enable  (state == WAIT),
        .expired (timeout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // flush outranks ready and ack; ready outranks the timeout in the same cycle
    always_comb begin
        state_next = state;
        stall      = 1'b1;
        ctrl_mult  = 1'b0;
        ctrl_div   = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) state_next = START;
            end
            START: begin
                ctrl_mult  = (op_q == OP_MUL);
                ctrl_div   = (op_q == OP_DIV);
                state_next = bus.flush ? IDLE : WAIT;
            end
            WAIT: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (bus.unit_ready || timeout) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                wb_valid = 1'b1;
                if (bus.flush || bus.wb_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
            op_q  <= OP_MUL;
        end else if (state == IDLE && accept) begin
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            tag_q <= bus.op_tag;
            op_q  <= bus.op_is_mul ? OP_MUL : OP_DIV;
        end
    end

    assign wb_load  = (state == WAIT) & ~bus.flush & (bus.unit_ready | timeout);
    assign wb_clear = bus.flush | ((state == DONE) & bus.wb_ack);

    // Writeback registers are zeroed whenever the op leaves DONE or is flushed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_data_q      <= '0;
            wb_tag_q       <= '0;
            wb_exception_q <= 1'b0;
            wb_rstatus_q   <= '0;
        end else if (wb_clear) begin
            wb_data_q      <= '0;
            wb_tag_q       <= '0;
            wb_exception_q <= 1'b0;
            wb_rstatus_q   <= '0;
        end else if (wb_load) begin
            wb_tag_q <= tag_q;
            if (bus.unit_ready) begin
                wb_data_q      <= bus.unit_result;
                wb_exception_q <= bus.unit_exception;
                wb_rstatus_q   <= bus.unit_exception ? fault_rstatus : '0;
            end else begin
                wb_data_q      <= '0;
                wb_exception_q <= 1'b1;
                wb_rstatus_q   <= fault_rstatus;
            end
        end
    end

    assign bus.stall          = stall;
    assign bus.unit_ctrl_mult = ctrl_mult;
    assign bus.unit_ctrl_div  = ctrl_div;
    assign bus.unit_a         = a_q;
    assign bus.unit_b         = b_q;
    assign bus.wb_valid       = wb_valid;
    assign bus.wb_data        = wb_data_q;
    assign bus.wb_tag         = wb_tag_q;
    assign bus.wb_exception   = wb_exception_q;
    assign bus.wb_rstatus     = wb_rstatus_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and randomized ops against
// a behavioural model of the muldiv unit and of the expected writeback.
module tb_muldiv_sequencer;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 40;
    localparam logic [31:0] RS_MUL = 32'd4;
    localparam logic [31:0] RS_DIV = 32'd5;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    int   mult_pulses;
    int   div_pulses;

    muldiv_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    muldiv_sequencer #(
        .WIDTH   (WIDTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (6)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (bus.unit_ctrl_mult) mult_pulses++;
        if (bus.unit_ctrl_div)  div_pulses++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    // Reference behaviour of the muldiv unit: 32-bit product with overflow, or quotient with div-by-zero
    function automatic void unit_model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] res, output bit exc);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        if (is_mul) begin
            res = prod[31:0];
            exc = (prod[63:32] != 32'd0);
        end else if (b == 32'd0) begin
            res = 32'hFFFF_FFFF;
            exc = 1'b1;
        end else begin
            res = a / b;
            exc = 1'b0;
        end
    endfunction

    task automatic check_quiet(input string tag);
        check_output({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        check_output({tag, "_stall"},    32'(bus.stall),    32'd0);
        check_output({tag, "_wb_data"},  bus.wb_data,       32'd0);
    endtask

    task automatic apply_stimulus(input bit is_mul, input bit is_div, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] tag, input int lat,
                                  input int ack_delay, input bit present_next, input logic [31:0] next_a);
        bit          mul_eff;
        logic [31:0] res;
        bit          exc;
        logic [31:0] exp_data;
        logic [31:0] exp_rs;
        bit          exp_exc;
        mul_eff = is_mul;
        unit_model(mul_eff, a, b, res, exc);
        if (lat <= TIMEOUT) begin
            exp_data = res;
            exp_exc  = exc;
            exp_rs   = exc ? (mul_eff ? RS_MUL : RS_DIV) : 32'd0;
        end else begin
            exp_data = 32'd0;
            exp_exc  = 1'b1;
            exp_rs   = mul_eff ? RS_MUL : RS_DIV;
        end

        @(negedge clock);
        mult_pulses = 0;
        div_pulses  = 0;
        bus.op_valid = 1'b1;  bus.op_is_mul = is_mul;  bus.op_is_div = is_div;
        bus.op_a = a;  bus.op_b = b;  bus.op_tag = tag;
        bus.flush = 1'b0;  bus.wb_ack = 1'b0;  bus.unit_ready = 1'b0;  bus.unit_exception = 1'b0;
        #1;
        check_output("accept_stall",    32'(bus.stall),          32'd1);
        check_output("accept_wb_valid", 32'(bus.wb_valid),       32'd0);
        check_output("accept_no_mult",  32'(bus.unit_ctrl_mult), 32'd0);
        check_output("accept_no_div",   32'(bus.unit_ctrl_div),  32'd0);

        @(negedge clock);
        bus.op_valid = 1'b0;  bus.op_a = $urandom;  bus.op_b = $urandom;
        #1;
        check_output("start_mult",  32'(bus.unit_ctrl_mult), 32'(mul_eff));
        check_output("start_div",   32'(bus.unit_ctrl_div),  32'(!mul_eff));
        check_output("start_a",     bus.unit_a, a);
        check_output("start_b",     bus.unit_b, b);
        check_output("start_stall", 32'(bus.stall), 32'd1);

        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clock);
            bus.unit_ready     = (k == lat);
            bus.unit_exception = (k == lat) && exc;
            bus.unit_result    = (k == lat) ? res : $urandom;
            #1;
            check_output("wait_wb_valid", 32'(bus.wb_valid), 32'd0);
            check_output("wait_stall",    32'(bus.stall),    32'd1);
            check_output("wait_no_pulse", 32'(bus.unit_ctrl_mult | bus.unit_ctrl_div), 32'd0);
            check_output("wait_a_stable", bus.unit_a, a);
            if (k == lat) break;
        end

        for (int d = 0; d <= ack_delay; d++) begin
            @(negedge clock);
            bus.unit_ready = 1'b0;  bus.unit_exception = 1'b0;  bus.unit_result = $urandom;
            bus.wb_ack = (d == ack_delay);
            if (present_next) begin
                bus.op_valid = 1'b1;  bus.op_is_mul = 1'b1;  bus.op_is_div = 1'b0;
                bus.op_a = next_a;  bus.op_b = next_a;  bus.op_tag = 5'd7;
            end
            #1;
            check_output("done_wb_valid",  32'(bus.wb_valid),     32'd1);
            check_output("done_wb_data",   bus.wb_data,           exp_data);
            check_output("done_wb_tag",    32'(bus.wb_tag),       32'(tag));
            check_output("done_wb_exc",    32'(bus.wb_exception), 32'(exp_exc));
            check_output("done_wb_rs",     bus.wb_rstatus,        exp_rs);
            check_output("done_stall",     32'(bus.stall),        32'd1);
            check_output("done_no_pulse",  32'(bus.unit_ctrl_mult | bus.unit_ctrl_div), 32'd0);
            check_output("done_a_stable",  bus.unit_a, a);
        end
        check_output("mult_pulse_count", 32'(mult_pulses), 32'(mul_eff));
        check_output("div_pulse_count",  32'(div_pulses),  32'(!mul_eff));
    endtask

    initial begin
        bit          m;
        bit          d;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        checks = 0;  errors = 0;  mult_pulses = 0;  div_pulses = 0;
        reset_n = 1'b0;
        bus.op_valid = 1'b0;  bus.op_is_mul = 1'b0;  bus.op_is_div = 1'b0;
        bus.op_a = '0;  bus.op_b = '0;  bus.op_tag = '0;  bus.flush = 1'b0;
        bus.unit_result = '0;  bus.unit_exception = 1'b0;  bus.unit_ready = 1'b0;  bus.wb_ack = 1'b0;
        #2;
        check_quiet("reset");
        check_output("reset_unit_a", bus.unit_a, 32'd0);
        check_output("reset_rs",     bus.wb_rstatus, 32'd0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;

        $display("[TB] mult 7x6 and div by zero");
        apply_stimulus(1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 4, 0, 1'b0, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd100, 32'd0, 5'd9, 3, 1, 1'b0, 32'd0);

        $display("[TB] timeout and ready-on-timeout boundary");
        apply_stimulus(1'b1, 1'b0, 32'd11, 32'd13, 5'd1, TIMEOUT + 5, 0, 1'b0, 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'd3, 32'd5, 5'd2, TIMEOUT, 0, 1'b0, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'd9, 32'd9, 5'd4, 1, 0, 1'b0, 32'd0);

        $display("[TB] ack held, second op waiting");
        apply_stimulus(1'b0, 1'b1, 32'd1000, 32'd7, 5'd30, 2, 10, 1'b1, 32'd21);
        apply_stimulus(1'b1, 1'b0, 32'd21, 32'd21, 5'd7, 2, 0, 1'b0, 32'd0);

        $display("[TB] flush in WAIT with late ready");
        @(negedge clock);
        bus.wb_ack = 1'b0;  bus.op_valid = 1'b1;  bus.op_is_mul = 1'b1;  bus.op_is_div = 1'b0;
        bus.op_a = 32'd5;  bus.op_b = 32'd5;  bus.op_tag = 5'd6;
        @(negedge clock);
        bus.op_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        bus.flush = 1'b1;
        #1 check_output("flush_cycle_stall", 32'(bus.stall), 32'd1);
        @(negedge clock);
        bus.flush = 1'b0;  bus.unit_ready = 1'b1;  bus.unit_result = 32'd25;
        #1 check_quiet("after_flush");
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            bus.unit_ready = 1'b0;
            #1 check_quiet("flush_idle");
        end
        apply_stimulus(1'b0, 1'b1, 32'd81, 32'd9, 5'd12, 2, 0, 1'b0, 32'd0);

        $display("[TB] asynchronous reset mid-WAIT");
        @(negedge clock);
        bus.wb_ack = 1'b0;  bus.op_valid = 1'b1;  bus.op_is_mul = 1'b1;  bus.op_is_div = 1'b0;
        bus.op_a = 32'd8;  bus.op_b = 32'd8;  bus.op_tag = 5'd5;
        @(negedge clock);
        bus.op_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_quiet("async_reset");
        check_output("async_reset_a",    bus.unit_a, 32'd0);
        check_output("async_reset_b",    bus.unit_b, 32'd0);
        check_output("async_reset_tag",  32'(bus.wb_tag), 32'd0);
        check_output("async_reset_pulse", 32'(bus.unit_ctrl_mult | bus.unit_ctrl_div), 32'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            bus.unit_ready = (j == 0);
            bus.unit_result = 32'd64;
            #1 check_quiet("post_reset");
        end
        bus.unit_ready = 1'b0;

        $display("[TB] randomized ops");
        for (int i = 0; i < 12; i++) begin
            m   = 1'($urandom_range(0, 1));
            d   = !m || ($urandom_range(0, 3) == 0);
            a   = $urandom;
            b   = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            lat = ($urandom_range(0, 5) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, 6));
            apply_stimulus(m, d, a, b, 5'($urandom_range(0, 31)), lat, int'($urandom_range(0, 3)), 1'b0, 32'd0);
        end
        @(negedge clock);
        bus.wb_ack = 1'b0;
        #1 check_quiet("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Controller that sequences the shared multi-cycle multiply/divide unit behind the ALU. Accepts one mult/div request from decode, stalls the pipeline, and drives the unit's single-cycle start pulses and latched operands. Waits for the unit's ready, then presents result, destination tag and rstatus code to writeback until acknowledged. Sits between the decode/execute pipeline register and the muldiv unit. Add/sub/logic/shift never pass through this block.

Parameters:
WIDTH, 32, operand/result width
TAG_W, 5, destination register tag width
TIMEOUT, 40, max WAIT cycles before forced abort with exception
CNT_W, 6, timeout counter width; must satisfy 2^CNT_W > TIMEOUT
RSTATUS_MUL, 4, rstatus value reported on mult exception
RSTATUS_DIV, 5, rstatus value reported on div exception

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
op_valid  in  1  decode presents an op this cycle
op_is_mul  in  1  op is mult (exclusive with op_is_div)
op_is_div  in  1  op is div
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
op_tag  in  TAG_W  destination register
flush  in  1  pipeline flush; abort in-flight op
stall  out  1  hold upstream pipeline
unit_ctrl_mult  out  1  one-cycle start pulse for mult
unit_ctrl_div  out  1  one-cycle start pulse for div
unit_a  out  WIDTH  latched operand A to unit
unit_b  out  WIDTH  latched operand B to unit
unit_result  in  WIDTH  unit result
unit_exception  in  1  unit overflow/div-by-zero, valid with unit_ready
unit_ready  in  1  unit result valid (one-cycle pulse)
wb_valid  out  1  result available to writeback
wb_data  out  WIDTH  result
wb_tag  out  TAG_W  destination register
wb_exception  out  1  exception flag
wb_rstatus  out  WIDTH  rstatus value; 0 if no exception
wb_ack  in  1  writeback consumed result

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs and internal registers 0. Reset mid-operation discards the op; no wb_valid is produced.
- States: IDLE, START, WAIT, DONE.
- Accept: in IDLE with op_valid & (op_is_mul|op_is_div) & !flush, latch op_a, op_b, op_tag and op type, then go to START. If both type bits are set, treat the op as mult.
- START: exactly one cycle. unit_ctrl_mult or unit_ctrl_div =1 according to the latched type. unit_a/unit_b hold latched values and stay stable through WAIT. Clear the timeout counter. Go to WAIT.
- WAIT: increment the counter each cycle.
  - unit_ready=1: capture unit_result into wb_data. Set wb_exception=unit_exception. Set wb_rstatus = RSTATUS_MUL or RSTATUS_DIV if exception, else 0. Go to DONE.
  - Counter reaches TIMEOUT with no ready: wb_data=0, wb_exception=1, wb_rstatus by op type. Go to DONE.
  - unit_ready in the same cycle as the timeout: ready wins.
- DONE: wb_valid=1, wb_data/tag/exception/rstatus held stable. On wb_ack, go to IDLE with wb_valid=0 next cycle.
- Back-to-back ops: a new op may not be accepted in the cycle of the wb_ack. The earliest accept is the following cycle in IDLE.
- stall (combinational) = (state!=IDLE) | (state==IDLE & op_valid & (op_is_mul|op_is_div) & !flush).
- Minimum latency, accept to wb_valid: 3 cycles plus unit latency (accept→START→WAIT(ready)→DONE).
- flush: in START, WAIT or DONE, go to IDLE next cycle. Clear wb_valid and all wb_* outputs. A unit_ready arriving in the flush cycle is dropped. A late unit_ready seen in IDLE is ignored.
- flush has priority over unit_ready and wb_ack.
- Start pulses never exceed one cycle and are never re-issued for the same op.

Decomposition:
- Shared package muldiv_pkg: state encoding (IDLE=0, START=1, WAIT=2, DONE=3), RSTATUS_MUL/RSTATUS_DIV constants, op-type encoding.
- One sub-module: muldiv_timeout_counter, a CNT_W up-counter with clear, enable and expired output.
- FSM, operand latches and result registers stay in the top level.

Test Plan:
- Mult 7×6, tag 3, unit ready after 4 WAIT cycles, no exception → exactly one unit_ctrl_mult pulse; wb_valid with wb_data=42, wb_tag=3, wb_rstatus=0; stall high from the accept cycle until the wb_ack cycle.
- Div 100÷0, unit_exception=1 with ready → wb_exception=1, wb_rstatus=5, wb_data=unit_result; unit_ctrl_div pulsed once.
- Mult where unit_ready never arrives → after 40 WAIT cycles, wb_valid=1, wb_exception=1, wb_rstatus=4, wb_data=0.
- Flush asserted in WAIT cycle 2, then unit_ready one cycle later → no wb_valid; state IDLE; stall low; next op accepted normally.
- wb_ack held low for 10 cycles in DONE → wb_* stable throughout. Second op presented during this time is not accepted until the cycle after wb_ack.
- reset_n pulsed low mid-WAIT (asynchronous, between edges) → all outputs 0 immediately, no wb_valid after release.
